iterative_muldiv_unit: RTL and testbench
========================================

ITERATIVE_MULDIV_UNIT -- requirements
Module: iterative_muldiv_unit

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, the operand/result width in bits; WIDTH SHALL be even and >= 4.
REQ-002 Port clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port rst  input  1  asynchronous, active-low reset.
REQ-004 Port flush  input  1  synchronous abort of any operation in progress.
REQ-005 Port in_valid  input  1  request valid.
REQ-006 Port in_ready  output  1  block can accept a request.
REQ-007 Port op  input  3  operation: 000 MUL, 001 MULHU, 010 MULH, 100 DIVU, 101 REMU, 110 DIV, 111 REM; 011 SHALL be treated as MUL.
REQ-008 Port a  input  WIDTH  first operand (multiplicand/dividend).
REQ-009 Port b  input  WIDTH  second operand (multiplier/divisor).
REQ-010 Port out_valid  output  1  result valid.
REQ-011 Port out_ready  input  1  consumer accepts result.
REQ-012 Port result  output  WIDTH  operation result.
REQ-013 Port busy  output  1  high when state is not IDLE.

Function
REQ-014 The block SHALL implement an FSM with states IDLE, BUSY, DONE.
REQ-015 in_ready SHALL equal (state == IDLE); a request is accepted on a rising edge where in_valid && in_ready && !flush.
REQ-016 On accept: op, a, b (as magnitudes for signed ops, plus result-sign flags) SHALL be captured, iteration counter cleared, state -> BUSY.
REQ-017 BUSY SHALL perform exactly one radix-2 iteration per cycle (shift-add for multiply, restoring shift-subtract for divide) for WIDTH cycles, independent of operand values.
REQ-018 On the edge completing iteration WIDTH (accept edge + WIDTH), result SHALL be written sign-corrected and state -> DONE; out_valid is first high in the following cycle.
REQ-019 MUL SHALL return low WIDTH bits of a*b; MULHU high WIDTH bits of unsigned 2*WIDTH product; MULH high WIDTH bits of signed product.
REQ-020 DIV/REM SHALL truncate toward zero; remainder sign SHALL equal dividend sign.
REQ-021 Divide by zero: DIVU/DIV result all-ones; REMU/REM result = a.
REQ-022 Signed overflow (a = most-negative, b = all-ones): DIV result = a; REM result = 0.
REQ-023 In DONE, out_valid SHALL be 1 and result SHALL hold stable until out_valid && out_ready on an edge, then state -> IDLE.
REQ-024 No new request SHALL be accepted in the cycle the result is consumed; earliest next accept is the following edge.
REQ-025 result SHALL be 0 whenever out_valid is 0.
REQ-026 flush high on an edge SHALL force state -> IDLE, discard any result, and block acceptance on that edge (flush wins over in_valid and out_ready).
REQ-027 Inputs a, b, op SHALL be ignored outside the accept edge; changing them during BUSY SHALL not affect the result.

Reset
REQ-028 rst low SHALL immediately (asynchronously) force state IDLE, counter 0, all datapath registers 0.
REQ-029 During and after reset: in_ready = 1, busy = 0, out_valid = 0, result = 0.
REQ-030 Reset asserted mid-operation SHALL abort it; no result SHALL appear after release.

Verification (WIDTH = 32)
REQ-031 MUL a=7, b=6 accepted at edge T -> out_valid first high after edge T+32, result = 0x0000002A; busy high cycles T+1..T+32 inclusive of DONE.
REQ-032 MULH a=0xFFFFFFFE, b=3 -> 0xFFFFFFFF; MULHU same operands -> 0x00000002; MUL -> 0xFFFFFFFA.
REQ-033 DIV a=0xFFFFFFF9 (-7), b=2 -> 0xFFFFFFFD; REM same -> 0xFFFFFFFF; DIVU a=5, b=0 -> 0xFFFFFFFF; REMU -> 0x00000005; DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000, REM -> 0.
REQ-034 Backpressure: out_ready low 10 cycles after out_valid -> out_valid, result stable, in_ready 0; out_ready high -> IDLE next edge, in_ready 1.
REQ-035 flush at iteration 16 with in_valid high -> IDLE, no accept that edge, out_valid never asserted; new request next edge completes correctly.
REQ-036 rst low at iteration 5 -> outputs at reset values immediately; after release, no out_valid until a new request completes 32 cycles later.

Source files
------------

// File: rtl/iterative_muldiv_unit.sv
// Radix-2 iterative multiply/divide unit: shift-add multiply, restoring divide,
// one iteration per cycle for WIDTH cycles, with a valid/ready request and result handshake.
`timescale 1ns/1ps
module iterative_muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  localparam logic [2:0] OP_MUL   = 3'b000;
  localparam logic [2:0] OP_MULHU = 3'b001;
  localparam logic [2:0] OP_MULH  = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b100;
  localparam logic [2:0] OP_REMU  = 3'b101;
  localparam logic [2:0] OP_DIV   = 3'b110;
  localparam logic [2:0] OP_REM   = 3'b111;

  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2:0]         op_q, op_d;
  logic               neg_q, neg_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [2*WIDTH-1:0] p_q, p_d;
  logic [WIDTH-1:0]   res_q, res_d;

  // Request decode: operand magnitudes and the sign of the final result.
  logic [2:0]       op_n;
  logic             signed_in, a_neg, b_neg, b_zero;
  logic [WIDTH-1:0] a_mag, b_mag;

  always_comb begin
    op_n      = (op == 3'b011) ? OP_MUL : op;
    signed_in = (op_n == OP_MULH) || (op_n == OP_DIV) || (op_n == OP_REM);
    a_neg     = signed_in && a[WIDTH-1];
    b_neg     = signed_in && b[WIDTH-1];
    b_zero    = (b == '0);
    a_mag     = a_neg ? (~a + 1'b1) : a;
    b_mag     = b_neg ? (~b + 1'b1) : b;
  end

  // One iteration of either algorithm; p holds {acc/remainder, multiplier/quotient}.
  logic [WIDTH:0]     mul_sum, rem_sh, diff;
  logic [2*WIDTH-1:0] mul_next, div_next, p_iter, p_neg;
  logic [WIDTH-1:0]   quo, rem, res_fin;

  always_comb begin
    mul_sum  = {1'b0, p_q[2*WIDTH-1:WIDTH]} + (p_q[0] ? {1'b0, b_q} : '0);
    mul_next = {mul_sum, p_q[WIDTH-1:1]};
    rem_sh   = p_q[2*WIDTH-1:WIDTH-1];
    diff     = rem_sh - {1'b0, b_q};
    div_next = diff[WIDTH] ? {rem_sh[WIDTH-1:0], p_q[WIDTH-2:0], 1'b0}
                           : {diff[WIDTH-1:0],   p_q[WIDTH-2:0], 1'b1};
    p_iter   = op_q[2] ? div_next : mul_next;
    p_neg    = ~p_iter + 1'b1;
    quo      = neg_q ? (~p_iter[WIDTH-1:0] + 1'b1) : p_iter[WIDTH-1:0];
    rem      = neg_q ? (~p_iter[2*WIDTH-1:WIDTH] + 1'b1) : p_iter[2*WIDTH-1:WIDTH];
    case (op_q)
      OP_MUL:           res_fin = p_iter[WIDTH-1:0];
      OP_MULHU:         res_fin = p_iter[2*WIDTH-1:WIDTH];
      OP_MULH:          res_fin = neg_q ? p_neg[2*WIDTH-1:WIDTH] : p_iter[2*WIDTH-1:WIDTH];
      OP_DIVU, OP_DIV:  res_fin = quo;
      OP_REMU, OP_REM:  res_fin = rem;
      default:          res_fin = '0;
    endcase
  end

  // NOTE: every always_comb target gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    neg_d   = neg_q;
    b_d     = b_q;
    p_d     = p_q;
    res_d   = res_q;
    case (state_q)
      IDLE: if (in_valid) begin
        op_d    = op_n;
        b_d     = b_mag;
        p_d     = {{WIDTH{1'b0}}, a_mag};
        cnt_d   = '0;
        state_d = BUSY;
        case (op_n)
          OP_MULH: neg_d = a_neg ^ b_neg;
          OP_DIV:  neg_d = (a_neg ^ b_neg) && !b_zero;  // x/0 stays all-ones regardless of sign
          OP_REM:  neg_d = a_neg;
          default: neg_d = 1'b0;
        endcase
      end
      BUSY: begin
        p_d   = p_iter;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          res_d   = res_fin;
          state_d = DONE;
        end
      end
      DONE: if (out_ready) begin
        res_d   = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (flush) begin
      state_d = IDLE;
      res_d   = '0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  // NOTE: datapath registers are reset too, so no stale operand or result survives a reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      neg_q   <= 1'b0;
      b_q     <= '0;
      p_q     <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      neg_q   <= neg_d;
      b_q     <= b_d;
      p_q     <= p_d;
      res_q   <= res_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign out_valid = (state_q == DONE);
  assign result    = out_valid ? res_q : '0;

endmodule

// File: tb/tb_iterative_muldiv_unit.sv
// Self-checking bench for iterative_muldiv_unit (WIDTH = 32): vector table, random
// vectors against an arithmetic model, and hand-written backpressure/flush/reset sequences.
`timescale 1ns/1ps
module tb_iterative_muldiv_unit;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst, flush, in_valid, in_ready, out_valid, out_ready, busy;
  logic [2:0]   op;
  logic [W-1:0] a, b, result;

  int tests  = 0;
  int failed = 0;
  logic [W-1:0] exp_q[$];

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp;
  } vec_t;

  vec_t vecs[20];

  iterative_muldiv_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference arithmetic written directly from the operation definitions.
  function automatic logic [W-1:0] model(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    logic [63:0] pu, ps;
    int sx, sy;
    pu = {32'b0, x} * {32'b0, y};
    ps = 64'($signed({{32{x[31]}}, x}) * $signed({{32{y[31]}}, y}));
    sx = x;
    sy = y;
    case (o)
      3'b001: return pu[63:32];
      3'b010: return ps[63:32];
      3'b100: return (y == 0) ? 32'hFFFF_FFFF : x / y;
      3'b101: return (y == 0) ? x : x % y;
      3'b110: if (y == 0) return 32'hFFFF_FFFF;
              else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return x;
              else return 32'(sx / sy);
      3'b111: if (y == 0) return x;
              else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 32'h0;
              else return 32'(sx % sy);
      default: return pu[31:0];
    endcase
  endfunction

  // Drive one request, accept it on the next edge, then scramble the inputs.
  task automatic issue(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                       input logic [W-1:0] exp);
    @(negedge clk);
    in_valid = 1'b1; op = o; a = x; b = y;
    exp_q.push_back(exp);
    @(posedge clk); #1;
    in_valid = 1'b0;
    op = 3'($urandom); a = $urandom; b = $urandom;
  endtask

  // Called #1 after the accept edge: measure latency, compare, then consume the result.
  task automatic collect(input string name);
    int n = 0;
    logic [W-1:0] e;
    check({name, " busy"}, {31'b0, busy}, 32'd1);
    while (!out_valid && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check({name, " latency"}, n, 32'd32);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
    check({name, " result"}, result, e);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({name, " idle after consume"}, {30'b0, in_ready, out_valid}, 32'b10);
  endtask

  initial begin
    vecs[0]  = '{3'b000, 32'd7,          32'd6,          32'h0000_002A};
    vecs[1]  = '{3'b010, 32'hFFFF_FFFE,  32'd3,          32'hFFFF_FFFF};
    vecs[2]  = '{3'b001, 32'hFFFF_FFFE,  32'd3,          32'h0000_0002};
    vecs[3]  = '{3'b000, 32'hFFFF_FFFE,  32'd3,          32'hFFFF_FFFA};
    vecs[4]  = '{3'b110, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD};
    vecs[5]  = '{3'b111, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF};
    vecs[6]  = '{3'b100, 32'd5,          32'd0,          32'hFFFF_FFFF};
    vecs[7]  = '{3'b101, 32'd5,          32'd0,          32'h0000_0005};
    vecs[8]  = '{3'b110, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000};
    vecs[9]  = '{3'b111, 32'h8000_0000,  32'hFFFF_FFFF,  32'h0000_0000};
    vecs[10] = '{3'b011, 32'd7,          32'd6,          32'h0000_002A};
    vecs[11] = '{3'b001, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFE};
    vecs[12] = '{3'b010, 32'h8000_0000,  32'h8000_0000,  32'h4000_0000};
    vecs[13] = '{3'b110, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD};
    vecs[14] = '{3'b111, 32'd7,          32'hFFFF_FFFE,  32'h0000_0001};
    vecs[15] = '{3'b100, 32'd100,        32'd7,          32'd14};
    vecs[16] = '{3'b101, 32'd100,        32'd7,          32'd2};
    vecs[17] = '{3'b110, 32'hFFFF_FFF9,  32'd0,          32'hFFFF_FFFF};
    vecs[18] = '{3'b111, 32'hFFFF_FFF9,  32'd0,          32'hFFFF_FFF9};
    vecs[19] = '{3'b010, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'h0000_0000};

    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    op = '0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset outputs", {28'b0, in_ready, busy, out_valid, 1'b0}, 32'b1000);
    check("reset result", result, 32'h0);
    @(negedge clk); rst = 1'b1;

    for (int i = 0; i < 20; i++) begin
      issue(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp);
      collect($sformatf("vec%0d op%0d", i, vecs[i].op));
    end

    for (int i = 0; i < 16; i++) begin
      logic [2:0]   o;
      logic [W-1:0] x, y;
      o = 3'($urandom_range(0, 7));
      x = $urandom;
      y = (i % 5 == 0) ? 32'h0 : ((i % 3 == 0) ? 32'($urandom_range(1, 300)) : $urandom);
      issue(o, x, y, model(o, x, y));
      collect($sformatf("rand%0d op%0d", i, o));
    end

    // Backpressure: result held 10 cycles while a request waits; consume edge accepts nothing.
    issue(3'b000, 32'd9, 32'd9, 32'd81);
    begin
      int n = 0;
      while (!out_valid && n < 200) begin
        @(posedge clk); #1;
        n++;
      end
      check("bp latency", n, 32'd32);
    end
    in_valid = 1'b1; op = 3'b000; a = 32'd3; b = 32'd5;
    for (int i = 0; i < 10; i++) begin
      check($sformatf("bp hold %0d", i), {29'b0, out_valid, in_ready, busy}, 32'b101);
      check($sformatf("bp result %0d", i), result, 32'd81);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0; in_valid = 1'b0;
    check("bp consume", {29'b0, out_valid, in_ready, busy}, 32'b010);
    check("bp result cleared", result, 32'h0);
    void'(exp_q.pop_front());

    // Flush at iteration 16 with a competing request; next request must complete cleanly.
    issue(3'b110, 32'd1000, 32'd3, 32'd333);
    repeat (15) @(posedge clk);
    @(negedge clk);
    flush = 1'b1; in_valid = 1'b1; op = 3'b000; a = 32'd11; b = 32'd13;
    @(posedge clk); #1;
    check("flush no accept", {30'b0, in_ready, busy}, 32'b10);
    void'(exp_q.pop_front());
    flush = 1'b0;
    exp_q.push_back(32'd143);
    @(posedge clk); #1;
    in_valid = 1'b0;
    collect("after flush");

    // Asynchronous reset at iteration 5: outputs return immediately, nothing emerges later.
    issue(3'b100, 32'd77, 32'd7, 32'd11);
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("async reset outputs", {28'b0, in_ready, busy, out_valid, 1'b0}, 32'b1000);
    check("async reset result", result, 32'h0);
    void'(exp_q.pop_front());
    @(negedge clk); rst = 1'b1;
    begin
      int seen = 0;
      for (int i = 0; i < 40; i++) begin
        @(posedge clk); #1;
        if (out_valid || busy) seen++;
      end
      check("no result after reset", seen, 32'd0);
    end
    issue(3'b101, 32'd77, 32'd8, 32'd5);
    collect("after reset");

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
